file_register: RTL and testbench

FILE_REGISTER -- requirements
Module: file_register

---
 rtl/file_register.sv | 44 ++++
 tb/tb_file_register.sv | 122 ++++++++++++
 2 files changed

// File: rtl/file_register.sv
// Three-port register file: two asynchronous read ports, one synchronous write port,
// plus a dedicated view of r15 (the instruction register). r0 always reads as zero.
module file_register #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] data_bus,
  output logic [DATA_WIDTH-1:0] bus_a,
  output logic [DATA_WIDTH-1:0] bus_b,
  output logic [DATA_WIDTH-1:0] bus_ir,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [ADDR_WIDTH-1:0] addr_d,
  input  logic                  reset,
  input  logic                  rw,
  input  logic                  clk
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREG];

  // Reset wins over a same-edge write; r0 is never loaded from the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (rw && (addr_d != '0)) begin
      regs[addr_d] <= data_bus;
    end
  end

  // Reads see stored state only, so a pending write appears after the edge.
  always_comb begin
    bus_a = '0;
    bus_b = '0;
    if (addr_a != '0) bus_a = regs[addr_a];
    if (addr_b != '0) bus_b = regs[addr_b];
  end

  assign bus_ir = regs[NREG-1];

endmodule

// File: tb/tb_file_register.sv
// Bench for file_register: a driver issues one cycle of inputs per step and queues the
// expected read-port values; a monitor on the falling edge pops and compares them.
module tb_file_register;
  localparam int W  = 16;
  localparam int AW = 4;

  logic [W-1:0]  data_bus;
  logic [W-1:0]  bus_a, bus_b, bus_ir;
  logic [AW-1:0] addr_a, addr_b, addr_d;
  logic          reset, rw, clk;

  int total = 0;
  int bad   = 0;

  logic [3*W-1:0] exp_q[$];
  logic [W-1:0]   model [16];

  file_register #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .data_bus(data_bus), .bus_a(bus_a), .bus_b(bus_b), .bus_ir(bus_ir),
    .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d),
    .reset(reset), .rw(rw), .clk(clk)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] rd(input logic [AW-1:0] a);
    return (a == 0) ? '0 : model[a];
  endfunction

  // One clock cycle: drive, queue pre-edge expectation, then apply the edge to the model.
  task automatic step(input logic rst, input logic wr, input logic [W-1:0] d,
                      input logic [AW-1:0] ad, input logic [AW-1:0] aa,
                      input logic [AW-1:0] ab, input bit chk);
    reset = rst; rw = wr; data_bus = d; addr_d = ad; addr_a = aa; addr_b = ab;
    if (chk) exp_q.push_back({rd(aa), rd(ab), model[15]});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) model[i] = '0;
    end else if (wr && ad != 0) begin
      model[ad] = d;
    end
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [3*W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bus_a",  bus_a,  e[3*W-1:2*W]);
        check("bus_b",  bus_b,  e[2*W-1:W]);
        check("bus_ir", bus_ir, e[W-1:0]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 'x;
    model[0] = '0;
    reset = 1'b0; rw = 1'b0; data_bus = '0; addr_a = '0; addr_b = '0; addr_d = '0;
    @(posedge clk); #1;

    // reset, then read every address
    step(1'b1, 1'b0, '0, 4'd0, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, '0, 4'd0, 4'(i), 4'(15 - i), 1'b1);

    // sweep write with all addresses equal; the following read shows the stored value
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 16'hFFDD, 4'(i), 4'(i), 4'(i), 1'b1);
      step(1'b0, 1'b0, 16'h0000, 4'(i), 4'(i), 4'(i), 1'b1);
    end

    // unique pattern
    for (int i = 1; i < 16; i++) step(1'b0, 1'b1, 16'h1000 + 16'(i), 4'(i), 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 16'h0000, 4'd0, 4'(i), 4'(15 - i), 1'b1);

    // hold
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'hAAAA, 4'd5, 4'd5, 4'd0, 1'b1);

    // reset priority, then a write with no bypass
    step(1'b1, 1'b1, 16'h1234, 4'd3, 4'd3, 4'd15, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 4'd0, 4'd3, 4'd15, 1'b1);
    step(1'b0, 1'b1, 16'h1234, 4'd3, 4'd3, 4'd3, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 4'd0, 4'd3, 4'd3, 1'b1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 16'($urandom),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 1'b1);
    end

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d left exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
